// File: rtl/cache_arbiter_if.sv
// L1 I/D miss ports, shared L2 port and grant counters for cache_arbiter.
// Requests and L2 strobes are levels held until the matching one-cycle resp pulse.
interface cache_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
);
   logic                  i_pmem_read;
   logic [ADDR_WIDTH-1:0] i_pmem_address;
   logic [LINE_WIDTH-1:0] i_pmem_rdata;
   logic                  i_pmem_resp;

   logic                  d_pmem_read;
   logic                  d_pmem_write;
   logic [ADDR_WIDTH-1:0] d_pmem_address;
   logic [LINE_WIDTH-1:0] d_pmem_wdata;
   logic [LINE_WIDTH-1:0] d_pmem_rdata;
   logic                  d_pmem_resp;

   logic                  l2_read;
   logic                  l2_write;
   logic [ADDR_WIDTH-1:0] l2_address;
   logic [LINE_WIDTH-1:0] l2_wdata;
   logic [LINE_WIDTH-1:0] l2_rdata;
   logic                  l2_resp;

   logic [15:0]           i_grant_count;
   logic [15:0]           d_grant_count;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  l2_rdata, l2_resp,
      output i_pmem_rdata, i_pmem_resp,
      output d_pmem_rdata, d_pmem_resp,
      output l2_read, l2_write, l2_address, l2_wdata,
      output i_grant_count, d_grant_count
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output l2_rdata, l2_resp,
      input  i_pmem_rdata, i_pmem_resp,
      input  d_pmem_rdata, d_pmem_resp,
      input  l2_read, l2_write, l2_address, l2_wdata,
      input  i_grant_count, d_grant_count
   );
endinterface

// File: rtl/cache_arbiter.sv
// Serialises I-cache and D-cache line traffic onto one L2 port with
// round-robin tie-breaking and per-port wrapping grant counters.
module cache_arbiter #(
   parameter int          ADDR_WIDTH       = 16,
   parameter int          LINE_WIDTH       = 128,
   parameter logic [15:0] GRANT_COUNT_INIT = 16'h0000
) (
   input  logic              clk,
   input  logic              reset,
   cache_arbiter_if.slave    bus,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t                state;
   state_t                state_next;

   logic                  last_grant_d;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic [LINE_WIDTH-1:0] hold_wdata;
   logic                  hold_write;
   logic [LINE_WIDTH-1:0] i_rdata_q;
   logic [LINE_WIDTH-1:0] d_rdata_q;
   logic [15:0]           i_cnt;
   logic [15:0]           d_cnt;

   logic                  want_i;
   logic                  want_d;
   logic                  grant_i;
   logic                  grant_d;
   logic                  serving;
   logic                  done_i;
   logic                  done_d;

   assign want_i = bus.i_pmem_read;
   assign want_d = bus.d_pmem_read | bus.d_pmem_write;

   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            // On a tie the port that was not granted last time wins.
            if (want_i && (!want_d || last_grant_d)) begin
               grant_i    = 1'b1;
               state_next = SERVE_I;
            end else if (want_d) begin
               grant_d    = 1'b1;
               state_next = SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (bus.l2_resp) state_next = RELEASE;
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_d <= 1'b1;
         hold_addr    <= '0;
         hold_wdata   <= '0;
         hold_write   <= 1'b0;
         i_cnt        <= GRANT_COUNT_INIT;
         d_cnt        <= GRANT_COUNT_INIT;
      end else if (grant_i) begin
         last_grant_d <= 1'b0;
         hold_addr    <= bus.i_pmem_address;
         hold_wdata   <= '0;
         hold_write   <= 1'b0;
         i_cnt        <= i_cnt + 16'd1;
      end else if (grant_d) begin
         last_grant_d <= 1'b1;
         hold_addr    <= bus.d_pmem_address;
         hold_wdata   <= bus.d_pmem_wdata;
         // Read and write together is a write-back.
         hold_write   <= bus.d_pmem_write;
         d_cnt        <= d_cnt + 16'd1;
      end
   end

   assign serving = (state == SERVE_I) || (state == SERVE_D);
   assign done_i  = (state == SERVE_I) && bus.l2_resp;
   assign done_d  = (state == SERVE_D) && bus.l2_resp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (done_i) i_rdata_q <= bus.l2_rdata;
         if (done_d) d_rdata_q <= bus.l2_rdata;
      end
   end

   // Completion is visible to the L1 in the same cycle as l2_resp.
   assign bus.i_pmem_resp   = done_i;
   assign bus.d_pmem_resp   = done_d;
   assign bus.i_pmem_rdata  = done_i ? bus.l2_rdata : i_rdata_q;
   assign bus.d_pmem_rdata  = done_d ? bus.l2_rdata : d_rdata_q;

   assign bus.l2_read       = serving && !hold_write;
   assign bus.l2_write      = serving &&  hold_write;
   assign bus.l2_address    = hold_addr;
   assign bus.l2_wdata      = hold_wdata;

   assign bus.i_grant_count = i_cnt;
   assign bus.d_grant_count = d_cnt;

   assign state_dbg         = state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a table of single-port transactions
// followed by hand-written tie, hold, reset, stray-resp and wrap sequences.
module tb_cache_arbiter;

   localparam int AW = 16;
   localparam int LW = 128;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_I    = 2'd1;
   localparam logic [1:0] S_D    = 2'd2;
   localparam logic [1:0] S_REL  = 2'd3;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] state_dbg;
   logic [1:0] wrap_state_dbg;

   cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
   cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) wbus ();

   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // Second instance starts its counters at 0xFFFF so one grant shows the wrap.
   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .GRANT_COUNT_INIT(16'hFFFF)) dut_wrap (
      .clk       (clk),
      .reset     (reset),
      .bus       (wbus.slave),
      .state_dbg (wrap_state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit            is_d;
      bit            rd;
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      logic [LW-1:0] rdata;
      int            lat;
      bit            exp_rd;
      bit            exp_wr;
      logic [15:0]   exp_i_cnt;
      logic [15:0]   exp_d_cnt;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_requests();
      bus.i_pmem_read  = 1'b0;
      bus.d_pmem_read  = 1'b0;
      bus.d_pmem_write = 1'b0;
   endtask

   task automatic clear_inputs();
      clear_requests();
      bus.i_pmem_address  = '0;
      bus.d_pmem_address  = '0;
      bus.d_pmem_wdata    = '0;
      bus.l2_rdata        = '0;
      bus.l2_resp         = 1'b0;
      wbus.i_pmem_read    = 1'b0;
      wbus.i_pmem_address = '0;
      wbus.d_pmem_read    = 1'b0;
      wbus.d_pmem_write   = 1'b0;
      wbus.d_pmem_address = '0;
      wbus.d_pmem_wdata   = '0;
      wbus.l2_rdata       = '0;
      wbus.l2_resp        = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      next_cycle();
   endtask

   // Entered at the start of an IDLE cycle; leaves at the start of the next IDLE cycle.
   task automatic run_txn(input int idx, input vec_t v);
      string         p;
      logic          got_resp;
      logic          oth_resp;
      logic [LW-1:0] got_rdata;
      p = $sformatf("v%0d", idx);
      if (v.is_d) begin
         bus.d_pmem_read    = v.rd;
         bus.d_pmem_write   = v.wr;
         bus.d_pmem_address = v.addr;
         bus.d_pmem_wdata   = v.wdata;
      end else begin
         bus.i_pmem_read    = 1'b1;
         bus.i_pmem_address = v.addr;
      end
      @(negedge clk);
      check({p, "_idle_state"}, LW'(state_dbg), LW'(S_IDLE));
      next_cycle();
      for (int c = 0; c <= v.lat; c++) begin
         if (c == v.lat) begin
            bus.l2_resp  = 1'b1;
            bus.l2_rdata = v.rdata;
         end
         @(negedge clk);
         check($sformatf("%s_c%0d_l2_read", p, c), LW'(bus.l2_read), LW'(v.exp_rd));
         check($sformatf("%s_c%0d_l2_write", p, c), LW'(bus.l2_write), LW'(v.exp_wr));
         check($sformatf("%s_c%0d_l2_address", p, c), LW'(bus.l2_address), LW'(v.addr));
         if (v.exp_wr) check($sformatf("%s_c%0d_l2_wdata", p, c), bus.l2_wdata, v.wdata);
         got_resp  = v.is_d ? bus.d_pmem_resp : bus.i_pmem_resp;
         oth_resp  = v.is_d ? bus.i_pmem_resp : bus.d_pmem_resp;
         got_rdata = v.is_d ? bus.d_pmem_rdata : bus.i_pmem_rdata;
         check($sformatf("%s_c%0d_resp", p, c), LW'(got_resp), LW'(c == v.lat));
         check($sformatf("%s_c%0d_other_resp", p, c), LW'(oth_resp), '0);
         if (c == v.lat) check({p, "_rdata"}, got_rdata, v.rdata);
         next_cycle();
      end
      bus.l2_resp  = 1'b0;
      bus.l2_rdata = {4{32'hDEAD_BEEF}};
      clear_requests();
      @(negedge clk);
      got_rdata = v.is_d ? bus.d_pmem_rdata : bus.i_pmem_rdata;
      check({p, "_rel_state"}, LW'(state_dbg), LW'(S_REL));
      check({p, "_rel_strobes"}, LW'({bus.l2_read, bus.l2_write}), '0);
      check({p, "_rel_resps"}, LW'({bus.i_pmem_resp, bus.d_pmem_resp}), '0);
      check({p, "_rdata_kept"}, got_rdata, v.rdata);
      check({p, "_i_count"}, LW'(bus.i_grant_count), LW'(v.exp_i_cnt));
      check({p, "_d_count"}, LW'(bus.d_grant_count), LW'(v.exp_d_cnt));
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h1230, '0, {16{8'hA5}}, 3, 1'b1, 1'b0, 16'd1, 16'd0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h4000, {16{8'h0F}}, '0, 2, 1'b0, 1'b1, 16'd1, 16'd1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h2340, '0, {16{8'h5A}}, 0, 1'b1, 1'b0, 16'd1, 16'd2};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h2350, {16{8'h3C}}, {16{8'h11}}, 1, 1'b0, 1'b1, 16'd1, 16'd3};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 16'hFFF0, '0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                  0, 1'b1, 1'b0, 16'd2, 16'd3};

      // Reset values
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      check("rst_state", LW'(state_dbg), LW'(S_IDLE));
      check("rst_strobes", LW'({bus.l2_read, bus.l2_write}), '0);
      check("rst_resps", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), '0);
      check("rst_l2_address", LW'(bus.l2_address), '0);
      check("rst_l2_wdata", bus.l2_wdata, '0);
      check("rst_i_rdata", bus.i_pmem_rdata, '0);
      check("rst_d_rdata", bus.d_pmem_rdata, '0);
      check("rst_counts", LW'({bus.i_grant_count, bus.d_grant_count}), '0);
      check("rst_wrap_counts", LW'({wbus.i_grant_count, wbus.d_grant_count}), LW'(32'hFFFF_FFFF));
      reset = 1'b0;
      next_cycle();

      for (int i = 0; i < 5; i++) run_txn(i, vecs[i]);

      // Tie right after reset: I, then D, then I again
      apply_reset();
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 16'h1000;
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_address = 16'h2000;
      next_cycle();
      bus.l2_resp  = 1'b1;
      bus.l2_rdata = {8{16'h1111}};
      @(negedge clk);
      check("tie1_state", LW'(state_dbg), LW'(S_I));
      check("tie1_addr", LW'(bus.l2_address), LW'(16'h1000));
      check("tie1_resps", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), LW'(2'b10));
      next_cycle();
      bus.l2_resp = 1'b0;
      @(negedge clk);
      check("tie_rel_state", LW'(state_dbg), LW'(S_REL));
      next_cycle();
      @(negedge clk);
      check("tie_idle_state", LW'(state_dbg), LW'(S_IDLE));
      next_cycle();
      bus.l2_resp  = 1'b1;
      bus.l2_rdata = {8{16'h2222}};
      @(negedge clk);
      check("tie2_state", LW'(state_dbg), LW'(S_D));
      check("tie2_addr", LW'(bus.l2_address), LW'(16'h2000));
      check("tie2_resps", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), LW'(2'b01));
      check("tie2_d_rdata", bus.d_pmem_rdata, {8{16'h2222}});
      next_cycle();
      bus.l2_resp = 1'b0;
      next_cycle();
      next_cycle();
      bus.l2_resp  = 1'b1;
      bus.l2_rdata = {8{16'h3333}};
      @(negedge clk);
      check("tie3_state", LW'(state_dbg), LW'(S_I));
      check("tie3_addr", LW'(bus.l2_address), LW'(16'h1000));
      check("tie3_resps", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), LW'(2'b10));
      next_cycle();
      bus.l2_resp = 1'b0;
      clear_requests();
      @(negedge clk);
      check("tie_counts", LW'({bus.i_grant_count, bus.d_grant_count}), LW'({16'd2, 16'd1}));
      next_cycle();

      // D address/data change after grant must not reach L2
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 16'h4000;
      bus.d_pmem_wdata   = {16{8'h0F}};
      next_cycle();
      @(negedge clk);
      check("hold_c1_write", LW'(bus.l2_write), LW'(1'b1));
      check("hold_c1_addr", LW'(bus.l2_address), LW'(16'h4000));
      next_cycle();
      bus.d_pmem_address = 16'h5000;
      bus.d_pmem_wdata   = {16{8'hFF}};
      @(negedge clk);
      check("hold_c2_addr", LW'(bus.l2_address), LW'(16'h4000));
      check("hold_c2_wdata", bus.l2_wdata, {16{8'h0F}});
      next_cycle();
      bus.l2_resp = 1'b1;
      @(negedge clk);
      check("hold_c3_addr", LW'(bus.l2_address), LW'(16'h4000));
      check("hold_c3_d_resp", LW'(bus.d_pmem_resp), LW'(1'b1));
      next_cycle();
      bus.l2_resp = 1'b0;
      clear_requests();
      next_cycle();

      // Reset while l2_read is high
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 16'h3000;
      next_cycle();
      @(negedge clk);
      check("rmid_read_before", LW'(bus.l2_read), LW'(1'b1));
      next_cycle();
      #2;
      reset        = 1'b1;
      bus.l2_resp  = 1'b1;
      bus.l2_rdata = {4{32'hCAFE_F00D}};
      #1;
      check("rmid_read_drop", LW'(bus.l2_read), '0);
      check("rmid_no_resp", LW'(bus.i_pmem_resp), '0);
      check("rmid_state", LW'(state_dbg), LW'(S_IDLE));
      check("rmid_counts", LW'({bus.i_grant_count, bus.d_grant_count}), '0);
      check("rmid_i_rdata", bus.i_pmem_rdata, '0);
      @(negedge clk);
      clear_requests();
      bus.l2_resp = 1'b0;
      reset = 1'b0;
      next_cycle();

      // Stray l2_resp while idle
      bus.l2_resp  = 1'b1;
      bus.l2_rdata = {4{32'h1234_5678}};
      @(negedge clk);
      check("stray_resps", LW'({bus.i_pmem_resp, bus.d_pmem_resp}), '0);
      check("stray_i_rdata", bus.i_pmem_rdata, '0);
      check("stray_d_rdata", bus.d_pmem_rdata, '0);
      next_cycle();
      bus.l2_resp = 1'b0;
      @(negedge clk);
      check("stray_state", LW'(state_dbg), LW'(S_IDLE));
      check("stray_counts", LW'({bus.i_grant_count, bus.d_grant_count}), '0);

      // Counter wrap 0xFFFF -> 0x0000 on each port
      next_cycle();
      wbus.i_pmem_read    = 1'b1;
      wbus.i_pmem_address = 16'h0040;
      next_cycle();
      wbus.l2_resp = 1'b1;
      @(negedge clk);
      check("wrap_i_state", LW'(wrap_state_dbg), LW'(S_I));
      check("wrap_i_count", LW'(wbus.i_grant_count), '0);
      check("wrap_i_resp", LW'(wbus.i_pmem_resp), LW'(1'b1));
      next_cycle();
      wbus.l2_resp     = 1'b0;
      wbus.i_pmem_read = 1'b0;
      next_cycle();
      wbus.d_pmem_read    = 1'b1;
      wbus.d_pmem_address = 16'h0080;
      next_cycle();
      wbus.l2_resp = 1'b1;
      @(negedge clk);
      check("wrap_d_count", LW'(wbus.d_grant_count), '0);
      check("wrap_i_count_kept", LW'(wbus.i_grant_count), '0);
      next_cycle();
      wbus.l2_resp     = 1'b0;
      wbus.d_pmem_read = 1'b0;
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
